data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter for a shared single-port data memory; fixed 3-cycle access.
// Optional DMARB_ADDR_CHECK_EN: out-of-range addresses are blocked and acked with an error.
module data_mem_arbiter #(
  parameter int DW    = 32,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [DW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wd,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rd,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [DW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wd,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rd,
  output logic          p1_err,
  output logic          mem_we,
  output logic [DW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wd;
  } req_t;

  state_t        state, nxt;
  req_t          lat, sel;
  logic          gnt, gnt_nxt, last, req_any, addr_bad;
  logic [DW-1:0] rsp;

`ifdef DMARB_ADDR_CHECK_EN
  localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);
  logic rsp_err;
  assign addr_bad = (lat.addr >= DEPTH_W);
`else
  assign addr_bad = 1'b0;
`endif

  // Contention goes to the port not served last; a lone requester always wins.
  assign req_any = p0_req | p1_req;
  assign gnt_nxt = (p0_req & p1_req) ? ~last : p1_req;
  assign sel     = gnt_nxt ? req_t'{p1_we, p1_addr, p1_wd} : req_t'{p0_we, p0_addr, p0_wd};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lat   <= '0;
      gnt   <= 1'b0;
      last  <= 1'b1;
      rsp   <= '0;
`ifdef DMARB_ADDR_CHECK_EN
      rsp_err <= 1'b0;
`endif
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (req_any) begin
          lat  <= sel;
          gnt  <= gnt_nxt;
          last <= gnt_nxt;
        end
        ACCESS: begin
          // mem_rd still shows the pre-write word during a store, so stores return the data written.
          rsp <= addr_bad ? '0 : (lat.we ? lat.wd : mem_rd);
`ifdef DMARB_ADDR_CHECK_EN
          rsp_err <= addr_bad;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt    = state;
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    p0_ack = 1'b0;
    p0_rd  = '0;
    p0_err = 1'b0;
    p1_ack = 1'b0;
    p1_rd  = '0;
    p1_err = 1'b0;
    case (state)
      IDLE: if (req_any) nxt = ACCESS;
      ACCESS: begin
        nxt    = RESP;
        mem_we = lat.we & ~addr_bad;
        mem_a  = addr_bad ? '0 : lat.addr;
        mem_wd = lat.wd;
      end
      RESP: begin
        nxt    = IDLE;
        p0_ack = ~gnt;
        p1_ack = gnt;
        p0_rd  = gnt ? '0 : rsp;
        p1_rd  = gnt ? rsp : '0;
`ifdef DMARB_ADDR_CHECK_EN
        p0_err = ~gnt & rsp_err;
        p1_err = gnt & rsp_err;
`endif
      end
      default: nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 64-word memory.
module tb_data_mem_arbiter;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [DW-1:0] p0_addr, p0_wd, p1_addr, p1_wd;
  logic          p0_ack, p0_err, p1_ack, p1_err;
  logic [DW-1:0] p0_rd, p1_rd;
  logic          mem_we, busy;
  logic [DW-1:0] mem_a, mem_wd, mem_rd;

  logic [DW-1:0] mem [0:63];
  logic          init;
  int            checks = 0;
  int            failures = 0;
  int            we_cnt;

  always #5 clk = ~clk;

  data_mem_arbiter #(.DW(DW), .DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wd(p0_wd),
    .p0_ack(p0_ack), .p0_rd(p0_rd), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wd(p1_wd),
    .p1_ack(p1_ack), .p1_rd(p1_rd), .p1_err(p1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy)
  );

  assign mem_rd = (mem_a < 64) ? mem[mem_a[5:0]] : '0;

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[3] <= 32'd7;
    end else if (mem_we && mem_a < 64) begin
      mem[mem_a[5:0]] <= mem_wd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    init = 1'b1; rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wd = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wd = '0;
    tick(); tick();
    init = 1'b0; rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_p0_ack", p0_ack, 0);
    chk("rst_p1_ack", p1_ack, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_p0_rd", p0_rd, 0);

    // p0 load of mem[3]=7: ack two cycles after the request is sampled
    p0_req = 1; p0_we = 0; p0_addr = 3;
    tick();
    chk("ld_acc_busy", busy, 1);
    chk("ld_acc_mem_a", mem_a, 3);
    chk("ld_acc_mem_we", mem_we, 0);
    chk("ld_acc_p0_ack", p0_ack, 0);
    tick();
    chk("ld_p0_ack", p0_ack, 1);
    chk("ld_p0_rd", p0_rd, 7);
    chk("ld_p1_ack", p1_ack, 0);
    chk("ld_p0_err", p0_err, 0);
    p0_req = 0;
    tick();
    chk("ld_idle_ack", p0_ack, 0);
    chk("ld_idle_busy", busy, 0);

    // p1 store 0x55 to addr 10, then back-to-back load of addr 10
    we_cnt = 0;
    p1_req = 1; p1_we = 1; p1_addr = 10; p1_wd = 32'h55;
    tick();
    we_cnt += int'(mem_we);
    chk("st_mem_a", mem_a, 10);
    chk("st_mem_wd", mem_wd, 32'h55);
    tick();
    we_cnt += int'(mem_we);
    chk("st_p1_ack", p1_ack, 1);
    chk("st_p1_rd", p1_rd, 32'h55);
    chk("st_p0_ack", p0_ack, 0);
    p1_we = 0;
    tick();
    we_cnt += int'(mem_we);
    chk("b2b_idle_busy", busy, 0);
    tick();
    we_cnt += int'(mem_we);
    chk("b2b_mem_a", mem_a, 10);
    tick();
    we_cnt += int'(mem_we);
    chk("b2b_p1_ack", p1_ack, 1);
    chk("b2b_p1_rd", p1_rd, 32'h55);
    chk("st_we_cycles", we_cnt, 1);
    chk("st_mem10", mem[10], 32'h55);
    p1_req = 0;
    tick();

    // Continuous contention after reset: p0 first, then strict alternation
    rst = 1; tick(); rst = 0;
    p0_req = 1; p0_we = 0; p0_addr = 3;
    p1_req = 1; p1_we = 0; p1_addr = 10;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("rr_p0_ack_c%0d", c), p0_ack, (c == 2 || c == 8) ? 1 : 0);
      chk($sformatf("rr_p1_ack_c%0d", c), p1_ack, (c == 5 || c == 11) ? 1 : 0);
      if (c == 2 || c == 8) chk($sformatf("rr_p0_rd_c%0d", c), p0_rd, 7);
      if (c == 5 || c == 11) chk($sformatf("rr_p1_rd_c%0d", c), p1_rd, 32'h55);
    end
    p0_req = 0; p1_req = 0;
    tick(); tick();
    chk("rr_drain_busy", busy, 0);

    // Reset during ACCESS of a p0 store: write lands, no ack
    p0_req = 1; p0_we = 1; p0_addr = 5; p0_wd = 32'hA5;
    tick();
    chk("rsta_mem_we", mem_we, 1);
    rst = 1; p0_req = 0;
    tick();
    rst = 0;
    chk("rsta_p0_ack", p0_ack, 0);
    chk("rsta_busy", busy, 0);
    chk("rsta_mem5", mem[5], 32'hA5);

    // Reset during RESP: ack still visible, idle afterwards
    p0_req = 1; p0_we = 0; p0_addr = 3;
    tick(); tick();
    rst = 1;
    #1;
    chk("rstr_p0_ack", p0_ack, 1);
    chk("rstr_p0_rd", p0_rd, 7);
    p0_req = 0;
    tick();
    rst = 0;
    chk("rstr_busy", busy, 0);

    // p1 store to out-of-range addr 64
    p1_req = 1; p1_we = 1; p1_addr = 64; p1_wd = 32'h99;
    tick();
`ifdef DMARB_ADDR_CHECK_EN
    chk("oor_mem_we", mem_we, 0);
    chk("oor_mem_a", mem_a, 0);
`else
    chk("oor_mem_we", mem_we, 1);
    chk("oor_mem_a", mem_a, 64);
`endif
    tick();
    chk("oor_p1_ack", p1_ack, 1);
    chk("oor_p0_ack", p0_ack, 0);
`ifdef DMARB_ADDR_CHECK_EN
    chk("oor_p1_err", p1_err, 1);
    chk("oor_p1_rd", p1_rd, 0);
`else
    chk("oor_p1_err", p1_err, 0);
    chk("oor_p1_rd", p1_rd, 32'h99);
`endif
    p1_req = 0;
    tick();
    chk("end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
